// File: rtl/jstk2_spi_responder.sv
// rtl/jstk2_spi_responder.sv - SPI mode-0 responder emulating a Pmod JSTK2 (5-byte frames)
module jstk2_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [1:0]  btn,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [39:0] rx_data,
    output logic [23:0] led_rgb
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS);
    localparam logic [7:0] CMD_LED  = 8'h84;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_d;
    logic                   sclk_d;
    logic [5:0]             bit_cnt;
    logic [39:0]            tx_shift;
    logic [39:0]            rx_shift;
    logic [39:0]            tx_image;

    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;

    assign tx_image = {x_pos[7:0], 6'b0, x_pos[9:8],
                       y_pos[7:0], 6'b0, y_pos[9:8],
                       6'b0, btn[1:0]};

    // Bring the asynchronous SPI pins into the clk domain; SS idles deselected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    // Frame FSM; ss_d is frozen in DONE so an SS fall arriving there is seen from IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ss_d       <= 1'b1;
            sclk_d     <= 1'b0;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            MISO       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rx_data    <= '0;
            led_rgb    <= '0;
        end else begin
            sclk_d     <= sclk_s;
            ss_d       <= (state == DONE) ? ss_d : ss_s;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        tx_shift <= tx_image;
                        MISO     <= tx_image[39];
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        // Deselect takes priority over any coincident clock edge
                        MISO  <= 1'b0;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[38:0], mosi_s};
                        if (bit_cnt != 6'd63) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt >= LAST_BIT) begin
                            MISO <= 1'b0;
                        end else if (bit_cnt != 6'd0) begin
                            tx_shift <= {tx_shift[38:0], 1'b0};
                            MISO     <= tx_shift[38];
                        end
                    end
                end
                DONE: begin
                    MISO <= 1'b0;
                    busy <= 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        frame_done <= 1'b1;
                        rx_data    <= rx_shift;
                        if (rx_shift[39:32] == CMD_LED) begin
                            led_rgb <= rx_shift[31:8];
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// tb/tb_jstk2_spi_responder.sv - directed bench for jstk2_spi_responder
module tb_jstk2_spi_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        SS = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic [1:0]  btn = '0;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [39:0] rx_data;
    logic [23:0] led_rgb;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [39:0] miso_cap;
    logic        extra;

    jstk2_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
        .clk(clk), .rst(rst), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .x_pos(x_pos), .y_pos(y_pos), .btn(btn), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err),
        .rx_data(rx_data), .led_rgb(led_rgb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_frame(input logic [39:0] mo, input int nbits,
                             output logic [39:0] mi, output logic ex);
        mi = '0;
        ex = 1'b0;
        SS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 40) ? mo[39-i] : 1'b0;
            wait_clk(HALF);
            if (i < 40) mi[39-i] = MISO;
            else ex = ex | MISO;
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
        wait_clk(HALF);
        SS   = 1'b1;
        MOSI = 1'b0;
        wait_clk(10);
    endtask

    initial begin
        wait_clk(3);
        check("reset_miso", 64'(MISO), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rx", 64'(rx_data), 64'd0);
        check("reset_led", 64'(led_rgb), 64'd0);
        rst = 1'b1;
        wait_clk(4);

        // 1: served image, MOSI all zero
        x_pos = 10'h2A5; y_pos = 10'h103; btn = 2'b10;
        fork
            spi_frame(40'h0, 40, miso_cap, extra);
            begin
                wait_clk(60);
                check("t1_busy_mid", 64'(busy), 64'd1);
            end
        join
        check("t1_miso", 64'(miso_cap), 64'hA502030102);
        check("t1_done", 64'(done_cnt), 64'd1);
        check("t1_err", 64'(err_cnt), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_rx", 64'(rx_data), 64'd0);

        // 2: LED command
        spi_frame(40'h84FF008000, 40, miso_cap, extra);
        check("t2_rx", 64'(rx_data), 64'h84FF008000);
        check("t2_led", 64'(led_rgb), 64'hFF0080);
        check("t2_done", 64'(done_cnt), 64'd2);

        // 3: non-LED command leaves LED alone
        spi_frame(40'hC011223344, 40, miso_cap, extra);
        check("t3_rx", 64'(rx_data), 64'hC011223344);
        check("t3_led", 64'(led_rgb), 64'hFF0080);

        // 4: short frame
        spi_frame(40'h84AAAAAAAA, 17, miso_cap, extra);
        check("t4_err", 64'(err_cnt), 64'd1);
        check("t4_done", 64'(done_cnt), 64'd3);
        check("t4_rx", 64'(rx_data), 64'hC011223344);
        check("t4_led", 64'(led_rgb), 64'hFF0080);
        check("t4_miso", 64'(MISO), 64'd0);

        // 5: overrun, then a normal frame
        spi_frame(40'h8411223300, 48, miso_cap, extra);
        check("t5_err", 64'(err_cnt), 64'd2);
        check("t5_miso40", 64'(miso_cap), 64'hA502030102);
        check("t5_extra", 64'(extra), 64'd0);
        check("t5_led", 64'(led_rgb), 64'hFF0080);
        spi_frame(40'h8401020300, 40, miso_cap, extra);
        check("t5_done", 64'(done_cnt), 64'd4);
        check("t5_led_new", 64'(led_rgb), 64'h010203);

        // 6: reset at bit 20
        SS = 1'b0;
        for (int i = 0; i < 20; i++) begin
            MOSI = i[0];
            wait_clk(HALF);
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_miso", 64'(MISO), 64'd0);
        check("t6_rst_rx", 64'(rx_data), 64'd0);
        check("t6_rst_led", 64'(led_rgb), 64'd0);
        SS = 1'b1;
        MOSI = 1'b0;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(10);
        check("t6_no_done", 64'(done_cnt), 64'd4);
        check("t6_no_err", 64'(err_cnt), 64'd2);

        // next frame, with x_pos changed mid-frame
        x_pos = 10'h155; y_pos = 10'h3FF; btn = 2'b01;
        fork
            spi_frame(40'h84AABBCC00, 40, miso_cap, extra);
            begin
                wait_clk(100);
                x_pos = 10'h000;
                btn   = 2'b10;
            end
        join
        check("t6_miso", 64'(miso_cap), 64'h5501FF0301);
        check("t6_rx", 64'(rx_data), 64'h84AABBCC00);
        check("t6_led", 64'(led_rgb), 64'hAABBCC);
        check("t6_done", 64'(done_cnt), 64'd5);
        check("t6_err", 64'(err_cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
